simon_iter_core: RTL and testbench

- Generic iterative SIMON block cipher engine. It supersedes the fixed-variant 96/144 top and is selectable at elaboration for any SIMON variant through N, M, T and ZSEL.
- Key expansion runs once per key and stores all T round keys internally, so both encryption and decryption are supported with no re-expansion.
- Computes one round per clock. Uses the codebase's load/done/read handshake. Sits between the host interface and the data path.

---
 rtl/simon_iter_core.sv | 173 +++++++++++++++++
 tb/tb_simon_iter_core.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_iter_core.sv
// Iterative SIMON engine for any variant: one round per clock. All round keys are
// expanded once per key and kept, so encryption and decryption share one expansion.
module simon_iter_core #(
  parameter int N    = 48,
  parameter int M    = 3,
  parameter int T    = 54,
  parameter int ZSEL = 3,
  parameter int Co   = 6
) (
  input  logic           clk,
  input  logic           R,
  input  logic           newKey,
  input  logic [M*N-1:0] key,
  output logic           ldKey,
  output logic           doneKey,
  input  logic           newData,
  input  logic           enc_dec,
  input  logic [2*N-1:0] plain,
  output logic           ldData,
  output logic           doneData,
  input  logic           readData,
  output logic [2*N-1:0] cipher
);

  localparam int AW = (T > 1) ? $clog2(T) : 1;
  localparam logic [Co-1:0] CNT_M    = Co'(M);
  localparam logic [Co-1:0] CNT_LAST = Co'(T - 1);
  localparam logic [N-1:0]  C3       = N'(3);

  // z_j sequences written left to right, so bit i of z_j sits at position 61-i
  localparam logic [4:0][61:0] Z_ALL = {
    62'b11010001111001101011011000100000010111000011001010010011101111,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b11111010001001010110000111001101111101000100101011000011100110
  };
  localparam logic [61:0] Z = Z_ALL[3'(ZSEL)];

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    return (v >> s) | (v << (N - s));
  endfunction

  function automatic logic [N-1:0] round_f(input logic [N-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  typedef enum logic [1:0] {IDLE, KEXP, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [N-1:0]  rk [T];
  logic [Co-1:0] count;
  logic [5:0]    z_idx;
  logic          enc;
  logic [N-1:0]  x, y, x_next, y_next, rkey;
  logic [N-1:0]  kexp_tmp, kexp_word;
  logic          key_go, data_go, z_bit;
  logic [AW-1:0] idx_cur, idx_m1, idx_m3, idx_mm, rk_idx;

  assign ldKey    = (state == IDLE) && !R;
  assign ldData   = (state == IDLE) && doneKey && !R && !newKey;
  assign doneData = (state == DONE);

  assign idx_cur = AW'(count);
  assign idx_m1  = AW'(count - Co'(1));
  assign idx_m3  = AW'(count - Co'(3));
  assign idx_mm  = AW'(count - CNT_M);
  // decryption walks the stored schedule backwards
  assign rk_idx  = enc ? AW'(count) : AW'(CNT_LAST - count);
  assign z_bit   = Z[6'd61 - z_idx];

  always_ff @(posedge clk) begin
    if (R) state <= IDLE;
    else   state <= state_next;
  end

  always_comb begin
    state_next = state;
    key_go     = 1'b0;
    data_go    = 1'b0;
    case (state)
      IDLE: begin
        if (newKey) begin
          state_next = KEXP;
          key_go     = 1'b1;
        end else if (newData && doneKey) begin
          state_next = RUN;
          data_go    = 1'b1;
        end
      end
      KEXP:    if (count == CNT_LAST) state_next = IDLE;
      RUN:     if (count == CNT_LAST) state_next = DONE;
      DONE:    if (readData) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    kexp_tmp = ror(rk[idx_m1], 3);
    if (M == 4) kexp_tmp = kexp_tmp ^ rk[idx_m3];
    kexp_tmp  = kexp_tmp ^ ror(kexp_tmp, 1);
    kexp_word = ~rk[idx_mm] ^ kexp_tmp ^ N'(z_bit) ^ C3;
  end

  always_comb begin
    rkey   = rk[rk_idx];
    x_next = x;
    y_next = y;
    if (enc) begin
      x_next = y ^ round_f(x) ^ rkey;
      y_next = x;
    end else begin
      y_next = x ^ round_f(y) ^ rkey;
      x_next = y;
    end
  end

  // Datapath: key store, round counter, block registers and the held result
  always_ff @(posedge clk) begin
    if (R) begin
      for (int i = 0; i < T; i++) rk[i] <= '0;
      count   <= '0;
      z_idx   <= '0;
      doneKey <= 1'b0;
      enc     <= 1'b0;
      x       <= '0;
      y       <= '0;
      cipher  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_go) begin
            for (int i = 0; i < M; i++) rk[i] <= key[i*N +: N];
            doneKey <= 1'b0;
            count   <= CNT_M;
            z_idx   <= '0;
          end else if (data_go) begin
            x     <= plain[2*N-1:N];
            y     <= plain[N-1:0];
            enc   <= enc_dec;
            count <= '0;
          end
        end
        KEXP: begin
          rk[idx_cur] <= kexp_word;
          z_idx       <= (z_idx == 6'd61) ? 6'd0 : z_idx + 6'd1;
          if (count == CNT_LAST) begin
            doneKey <= 1'b1;
            count   <= '0;
          end else begin
            count <= count + Co'(1);
          end
        end
        RUN: begin
          x <= x_next;
          y <= y_next;
          if (count == CNT_LAST) begin
            cipher <= {x_next, y_next};
            count  <= '0;
          end else begin
            count <= count + Co'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_iter_core.sv
// Self-checking bench for simon_iter_core: SIMON32/64, SIMON64/128 and the
// default SIMON96/144 instance share a clock and reset.
module tb_simon_iter_core;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic R;
  logic newKey_v   [ND];
  logic newData_v  [ND];
  logic enc_dec_v  [ND];
  logic readData_v [ND];
  logic ldKey_v    [ND];
  logic doneKey_v  [ND];
  logic ldData_v   [ND];
  logic doneData_v [ND];

  logic [63:0]  key0;
  logic [127:0] key1;
  logic [143:0] key2;
  logic [31:0]  plain0, cipher0;
  logic [63:0]  plain1, cipher1;
  logic [95:0]  plain2, cipher2;

  int total = 0;
  int bad   = 0;
  int lat;
  logic [127:0] ct, ct2, p;
  logic [255:0] rkey;

  typedef struct {
    int           dev;
    logic [127:0] pt;
    logic         enc;
    logic [127:0] ct;
    int           lat;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  simon_iter_core #(.N(16), .M(4), .T(32), .ZSEL(0), .Co(6)) dut0 (
    .clk(clk), .R(R), .newKey(newKey_v[0]), .key(key0), .ldKey(ldKey_v[0]),
    .doneKey(doneKey_v[0]), .newData(newData_v[0]), .enc_dec(enc_dec_v[0]),
    .plain(plain0), .ldData(ldData_v[0]), .doneData(doneData_v[0]),
    .readData(readData_v[0]), .cipher(cipher0)
  );

  simon_iter_core #(.N(32), .M(4), .T(44), .ZSEL(3), .Co(6)) dut1 (
    .clk(clk), .R(R), .newKey(newKey_v[1]), .key(key1), .ldKey(ldKey_v[1]),
    .doneKey(doneKey_v[1]), .newData(newData_v[1]), .enc_dec(enc_dec_v[1]),
    .plain(plain1), .ldData(ldData_v[1]), .doneData(doneData_v[1]),
    .readData(readData_v[1]), .cipher(cipher1)
  );

  simon_iter_core dut2 (
    .clk(clk), .R(R), .newKey(newKey_v[2]), .key(key2), .ldKey(ldKey_v[2]),
    .doneKey(doneKey_v[2]), .newData(newData_v[2]), .enc_dec(enc_dec_v[2]),
    .plain(plain2), .ldData(ldData_v[2]), .doneData(doneData_v[2]),
    .readData(readData_v[2]), .cipher(cipher2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] get_cipher(input int d);
    case (d)
      0:       return 128'(cipher0);
      1:       return 128'(cipher1);
      default: return 128'(cipher2);
    endcase
  endfunction

  task automatic set_key(input int d, input logic [255:0] k);
    case (d)
      0:       key0 = k[63:0];
      1:       key1 = k[127:0];
      default: key2 = k[143:0];
    endcase
  endtask

  task automatic set_plain(input int d, input logic [127:0] v);
    case (d)
      0:       plain0 = v[31:0];
      1:       plain1 = v[63:0];
      default: plain2 = v[95:0];
    endcase
  endtask

  // Key load with optional simultaneous data request; latency counts edges from acceptance
  task automatic load_key(input int d, input logic [255:0] k, input int exp_lat,
                          input logic with_data, input string name);
    int n;
    check_output({name, " ldKey"}, 128'(ldKey_v[d]), 128'd1);
    set_key(d, k);
    newKey_v[d] = 1'b1;
    if (with_data) begin
      enc_dec_v[d] = 1'b1;
      newData_v[d] = 1'b1;
      #1;
      check_output({name, " ldData"}, 128'(ldData_v[d]), 128'd0);
    end
    tick();
    newKey_v[d]  = 1'b0;
    newData_v[d] = 1'b0;
    n = 1;
    while (doneKey_v[d] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check_output({name, " latency"}, 128'(n), 128'(exp_lat));
    if (with_data) check_output({name, " data ignored"}, 128'(doneData_v[d]), 128'd0);
  endtask

  task automatic apply_stimulus(input int d, input logic [127:0] pt, input logic e,
                                output int n_out, output logic [127:0] c_out);
    int n;
    set_plain(d, pt);
    enc_dec_v[d] = e;
    newData_v[d] = 1'b1;
    tick();
    newData_v[d] = 1'b0;
    n = 1;
    while (doneData_v[d] !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    n_out = n;
    c_out = get_cipher(d);
  endtask

  task automatic release_result(input int d, input logic [127:0] held, input string name);
    readData_v[d] = 1'b1;
    tick();
    readData_v[d] = 1'b0;
    check_output({name, " doneData drop"}, 128'(doneData_v[d]), 128'd0);
    check_output({name, " cipher kept"}, get_cipher(d), held);
  endtask

  initial begin
    vecs[0] = '{0, 128'h65656877,         1'b1, 128'hc69be9bb,         33};
    vecs[1] = '{0, 128'hc69be9bb,         1'b0, 128'h65656877,         33};
    vecs[2] = '{1, 128'h656b696c20646e75, 1'b1, 128'h44c8fc20b9dfa07a, 45};
    vecs[3] = '{1, 128'h44c8fc20b9dfa07a, 1'b0, 128'h656b696c20646e75, 45};
    vecs[4] = '{0, 128'h65656877,         1'b1, 128'hc69be9bb,         33};

    R = 1'b1;
    for (int d = 0; d < ND; d++) begin
      newKey_v[d] = 1'b0; newData_v[d] = 1'b0;
      enc_dec_v[d] = 1'b0; readData_v[d] = 1'b0;
    end
    key0 = '0; key1 = '0; key2 = '0;
    plain0 = '0; plain1 = '0; plain2 = '0;
    tick();
    tick();

    check_output("reset ldKey low", 128'(ldKey_v[0]), 128'd0);
    check_output("reset doneKey", 128'(doneKey_v[0]), 128'd0);
    check_output("reset doneData", 128'(doneData_v[0]), 128'd0);
    check_output("reset cipher", get_cipher(0), 128'd0);
    R = 1'b0;
    #1;
    check_output("post-reset ldKey", 128'(ldKey_v[0]), 128'd1);
    check_output("post-reset ldData", 128'(ldData_v[0]), 128'd0);

    // data before any key must not start a run
    set_plain(0, 128'h65656877);
    enc_dec_v[0] = 1'b1;
    newData_v[0] = 1'b1;
    tick();
    newData_v[0] = 1'b0;
    check_output("nokey stays idle", 128'(ldKey_v[0]), 128'd1);
    repeat (40) tick();
    check_output("nokey no result", 128'(doneData_v[0]), 128'd0);

    load_key(0, 256'h1918111009080100, 29, 1'b0, "key0");
    load_key(1, 256'h1b1a1918131211100b0a090803020100, 41, 1'b0, "key1");

    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i].dev, vecs[i].pt, vecs[i].enc, lat, ct);
      check_output($sformatf("vec%0d latency", i), 128'(lat), 128'(vecs[i].lat));
      check_output($sformatf("vec%0d cipher", i), ct, vecs[i].ct);
      release_result(vecs[i].dev, vecs[i].ct, $sformatf("vec%0d", i));
    end

    // key request while DONE is ignored; a later key load leaves the held result alone
    apply_stimulus(0, 128'h65656877, 1'b1, lat, ct);
    set_key(0, 256'h0123456789abcdef);
    newKey_v[0] = 1'b1;
    tick();
    newKey_v[0] = 1'b0;
    check_output("done newKey ignored", 128'(doneKey_v[0]), 128'd1);
    check_output("done ldKey low", 128'(ldKey_v[0]), 128'd0);
    release_result(0, 128'hc69be9bb, "done hold");
    load_key(0, 256'h0123456789abcdef, 29, 1'b0, "key0 alt");
    check_output("new key keeps cipher", get_cipher(0), 128'hc69be9bb);

    load_key(0, 256'h1918111009080100, 29, 1'b1, "key0 with data");
    apply_stimulus(0, 128'h65656877, 1'b1, lat, ct);
    check_output("rekey cipher", ct, 128'hc69be9bb);
    release_result(0, 128'hc69be9bb, "rekey");

    // default variant: stall then many round trips under one random key
    rkey = {$urandom, $urandom, $urandom, $urandom, $urandom};
    load_key(2, rkey, 52, 1'b0, "key2");
    p = 128'({$urandom, $urandom, $urandom});
    apply_stimulus(2, p, 1'b1, lat, ct);
    check_output("def latency", 128'(lat), 128'd55);
    repeat (5) tick();
    check_output("stall doneData", 128'(doneData_v[2]), 128'd1);
    check_output("stall cipher", get_cipher(2), ct);
    release_result(2, ct, "stall");
    readData_v[2] = 1'b1;
    tick();
    readData_v[2] = 1'b0;
    check_output("idle readData ignored", 128'(ldData_v[2]), 128'd1);
    apply_stimulus(2, ct, 1'b0, lat, ct2);
    check_output("stall roundtrip", ct2, p);
    release_result(2, ct2, "stall dec");

    for (int i = 0; i < 100; i++) begin
      p = 128'({$urandom, $urandom, $urandom});
      apply_stimulus(2, p, 1'b1, lat, ct);
      readData_v[2] = 1'b1; tick(); readData_v[2] = 1'b0;
      apply_stimulus(2, ct, 1'b0, lat, ct2);
      readData_v[2] = 1'b1; tick(); readData_v[2] = 1'b0;
      check_output($sformatf("roundtrip %0d", i), ct2, p);
    end

    // reset in the middle of a run drops the key and the held result
    set_plain(0, 128'h65656877);
    enc_dec_v[0] = 1'b1;
    newData_v[0] = 1'b1;
    tick();
    newData_v[0] = 1'b0;
    repeat (10) tick();
    R = 1'b1;
    tick();
    check_output("midrun ldKey low", 128'(ldKey_v[0]), 128'd0);
    check_output("midrun doneKey", 128'(doneKey_v[0]), 128'd0);
    check_output("midrun doneData", 128'(doneData_v[0]), 128'd0);
    check_output("midrun cipher", get_cipher(0), 128'd0);
    R = 1'b0;
    #1;
    check_output("midrun ldKey after", 128'(ldKey_v[0]), 128'd1);
    newData_v[0] = 1'b1;
    tick();
    newData_v[0] = 1'b0;
    check_output("midrun data ignored", 128'(ldKey_v[0]), 128'd1);
    repeat (40) tick();
    check_output("midrun no result", 128'(doneData_v[0]), 128'd0);
    load_key(0, 256'h1918111009080100, 29, 1'b0, "key0 again");
    apply_stimulus(0, 128'h65656877, 1'b1, lat, ct);
    check_output("after reset cipher", ct, 128'hc69be9bb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
